// File: rtl/bf16_minmax_issue.sv
// Issue stage for the bf16 min/max FU: FIFO-buffered requests, one at a time to the FU, tagged result out.
// Latency: accept -> fu_enable 2 cycles -> out_valid 4 cycles; illegal op -> out_valid 2 cycles.
// Backpressure: in_ready drops when the FIFO is full; out_* holds until out_ready, which stalls issue.
//
// Ports: clk/reset (async, active-low); in_* request valid/ready port; fu_* issue pulse, operands and
// registered FU result; out_* response valid/ready port with tag and flags; sticky_fpcsr/sticky_clr
// accumulated flags; count is FIFO occupancy.

// Generic in-order FIFO: push when not full, pop when not empty, head visible combinationally.
// Latency: an entry is visible at the head the cycle after its push.
// Backpressure: a push while full is dropped, so the caller must gate push with ~full.
module bf16_minmax_issue_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    output logic [W-1:0]     head_dat,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_dat = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries data only; it never needs a reset value.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module bf16_minmax_issue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_operand_a,
    input  logic [15:0]                in_operand_b,
    input  logic [3:0]                 in_operation,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       fu_enable,
    output logic [15:0]                fu_operand_a,
    output logic [15:0]                fu_operand_b,
    output logic [3:0]                 fu_operation,
    input  logic [15:0]                fu_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_result,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_invalid,
    output logic                       out_illegal,
    output logic [3:0]                 sticky_fpcsr,
    input  logic                       sticky_clr,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int          CNT_W  = $clog2(DEPTH + 1);
    localparam logic [3:0]  OP_MIN = 4'b0011;
    localparam logic [3:0]  OP_MAX = 4'b0010;
    localparam logic [15:0] QNAN   = 16'h7FC0;

    typedef struct packed {
        logic [15:0]      a;
        logic [15:0]      b;
        logic [3:0]       op;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, OUT} state_t;

    state_t state;
    state_t state_nxt;
    req_t   push_req;
    req_t   head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   push;
    logic   pop;
    logic   issue;
    logic   load_ill;
    logic   load_capt;
    logic   out_done;
    logic   head_legal;
    logic   head_nan;
    logic   sticky_ill;
    logic   sticky_inv;

    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
    endfunction

    // in_ready is forced low while reset is held so nothing is offered acceptance during reset.
    assign in_ready = reset & ~fifo_full;
    assign push     = in_valid & in_ready;
    assign push_req = '{a: in_operand_a, b: in_operand_b, op: in_operation, tag: in_tag};

    bf16_minmax_issue_fifo #(
        .W     ($bits(req_t)),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (push_req),
        .pop      (pop),
        .head_dat (head),
        .count    (count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // The head stays in the FIFO until its result is captured, so it is the reference for tag and NaN flags.
    assign head_legal = (head.op == OP_MIN) || (head.op == OP_MAX);
    assign head_nan   = is_nan(head.a) | is_nan(head.b);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        issue     = 1'b0;
        load_ill  = 1'b0;
        load_capt = 1'b0;
        out_done  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    if (head_legal) begin
                        issue     = 1'b1;
                        state_nxt = EXEC;
                    end else begin
                        load_ill  = 1'b1;
                        pop       = 1'b1;
                        state_nxt = OUT;
                    end
                end
            end
            EXEC: state_nxt = CAPT;
            CAPT: begin
                load_capt = 1'b1;
                pop       = 1'b1;
                state_nxt = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fu_enable    <= 1'b0;
            fu_operand_a <= '0;
            fu_operand_b <= '0;
            fu_operation <= '0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_tag      <= '0;
            out_invalid  <= 1'b0;
            out_illegal  <= 1'b0;
        end else begin
            fu_enable <= issue;
            if (issue) begin
                fu_operand_a <= head.a;
                fu_operand_b <= head.b;
                fu_operation <= head.op;
            end
            if (load_ill) begin
                out_result  <= QNAN;
                out_tag     <= head.tag;
                out_invalid <= 1'b0;
                out_illegal <= 1'b1;
                out_valid   <= 1'b1;
            end
            if (load_capt) begin
                out_result  <= fu_result;
                out_tag     <= head.tag;
                out_invalid <= head_nan;
                out_illegal <= 1'b0;
                out_valid   <= 1'b1;
            end
            if (out_done) out_valid <= 1'b0;
        end
    end

    // Clear first, then set, so a set in the same cycle as a clear survives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_ill <= 1'b0;
            sticky_inv <= 1'b0;
        end else begin
            if (sticky_clr) begin
                sticky_ill <= 1'b0;
                sticky_inv <= 1'b0;
            end
            if (load_ill)              sticky_ill <= 1'b1;
            if (load_capt && head_nan) sticky_inv <= 1'b1;
        end
    end

    assign sticky_fpcsr = {sticky_ill, sticky_inv, 2'b00};
endmodule
